// File: rtl/wu_pkg.sv
// Shared types and constants for the wake-up latency logger.
// Class encodings, default window limits and entry layout live here.
package wu_pkg;
    localparam int LAT_W      = 17;
    localparam int CNT_W      = 20;
    localparam int WIN_LO_DEF = 60000;
    localparam int WIN_HI_DEF = 75000;
    localparam int DEPTH_DEF  = 1024;

    typedef enum logic [1:0] {
        CLS_TP   = 2'b00,
        CLS_FP   = 2'b01,
        CLS_MISS = 2'b10,
        CLS_SPUR = 2'b11
    } cls_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_e;

    typedef struct packed {
        cls_e             cls;
        logic [LAT_W-1:0] lat;
    } log_entry_t;

    localparam int ENTRY_W = $bits(log_entry_t);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction
endpackage

// File: rtl/wu_latency_logger_if.sv
// Show-ahead read port of the latency log.
// The logger is the slave; the consumer draining entries is the master.
interface wu_latency_logger_if;
    logic        rd_en;
    logic        rd_valid;
    logic [18:0] rd_data;

    modport master (output rd_en, input rd_valid, input rd_data);
    modport slave  (input rd_en, output rd_valid, output rd_data);
endinterface

// File: rtl/wu_log_fifo.sv
// Synchronous show-ahead FIFO for log entries; DEPTH must be a power of two >= 2.
// A write while full is accepted only if a pop happens on the same edge.
module wu_log_fifo #(
    parameter int DEPTH = 1024,
    parameter int W     = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          rd_ok, wr_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/wu_latency_logger.sv
// Measures trigger->wake latency, classifies it (TP/FP/MISS) and logs it to a FIFO.
// Optional WU_SPURIOUS_LOG_EN logs wake edges seen while idle as class SPUR.
module wu_latency_logger
    import wu_pkg::*;
#(
    parameter int WIN_LO = WIN_LO_DEF,
    parameter int WIN_HI = WIN_HI_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic             clki,
    input  logic             rst,
    input  logic             trig_to_siggen,
    input  logic             wake_up,
    wu_latency_logger_if.slave rd,
    output logic [CNT_W-1:0] tp_cnt,
    output logic [CNT_W-1:0] fp_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             overflow
);
    logic [2:0] trig_sr, wake_sr;
    logic [1:0] prim;
    logic       trig_ok, wake_ok;
    logic       trig_edge, wake_edge;

    // An edge only counts once the line has been seen low on a genuine sample,
    // so a line already high at reset release cannot fake an event.
    always_ff @(posedge clki) begin
        if (rst) begin
            trig_sr <= '0;
            wake_sr <= '0;
            prim    <= '0;
            trig_ok <= 1'b0;
            wake_ok <= 1'b0;
        end else begin
            trig_sr <= {trig_sr[1:0], trig_to_siggen};
            wake_sr <= {wake_sr[1:0], wake_up};
            prim    <= {prim[0], 1'b1};
            trig_ok <= trig_ok || (prim[1] && !trig_sr[1]);
            wake_ok <= wake_ok || (prim[1] && !wake_sr[1]);
        end
    end

    assign trig_edge = trig_ok && (trig_sr[2:1] == 2'b01);
    assign wake_edge = wake_ok && (wake_sr[2:1] == 2'b01);

    state_e           state, state_nxt;
    logic [LAT_W-1:0] tim_cnt, tim_nxt;
    logic             log_vld, log_vld_nxt;
    log_entry_t       log_q, log_nxt;

    always_ff @(posedge clki) begin
        if (rst) begin
            state   <= IDLE;
            tim_cnt <= '0;
            log_vld <= 1'b0;
            log_q   <= '0;
        end else begin
            state   <= state_nxt;
            tim_cnt <= tim_nxt;
            log_vld <= log_vld_nxt;
            log_q   <= log_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tim_nxt     = tim_cnt;
        log_vld_nxt = 1'b0;
        log_nxt     = '0;
        case (state)
            IDLE: begin
                if (trig_edge) begin
                    state_nxt = ARMED;
                    tim_nxt   = '0;
`ifdef WU_SPURIOUS_LOG_EN
                end else if (wake_edge) begin
                    log_vld_nxt = 1'b1;
                    log_nxt.cls = CLS_SPUR;
                    log_nxt.lat = '0;
`endif
                end
            end
            ARMED: begin
                if (wake_edge) begin
                    state_nxt   = IDLE;
                    log_vld_nxt = 1'b1;
                    log_nxt.cls = (tim_cnt < LAT_W'(WIN_LO)) ? CLS_FP : CLS_TP;
                    log_nxt.lat = tim_cnt;
                end else if (tim_cnt == LAT_W'(WIN_HI - 1)) begin
                    state_nxt   = IDLE;
                    log_vld_nxt = 1'b1;
                    log_nxt.cls = CLS_MISS;
                    log_nxt.lat = LAT_W'(WIN_HI);
                end else begin
                    tim_nxt = tim_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    logic             fifo_empty, fifo_full, fifo_drop;
    logic [ENTRY_W-1:0] fifo_rd_data;

    wu_log_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clk     (clki),
        .rst     (rst),
        .wr_en   (log_vld),
        .wr_data (log_q),
        .rd_en   (rd.rd_en),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign rd.rd_valid = !fifo_empty;
    assign rd.rd_data  = fifo_rd_data;
    assign fifo_drop   = log_vld && fifo_full && !(rd.rd_en && !fifo_empty);

    always_ff @(posedge clki) begin
        if (rst) begin
            tp_cnt   <= '0;
            fp_cnt   <= '0;
            miss_cnt <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (log_vld) begin
                case (log_q.cls)
                    CLS_TP:   tp_cnt   <= sat_inc(tp_cnt);
                    CLS_FP:   fp_cnt   <= sat_inc(fp_cnt);
                    CLS_MISS: miss_cnt <= sat_inc(miss_cnt);
                    default:  ;
                endcase
            end
            if (fifo_drop) begin
                drop_cnt <= sat_inc(drop_cnt);
                overflow <= 1'b1;
            end
        end
    end
endmodule
